// File: rtl/struct_copy_fsm.sv
// Staged struct copier: fields are written individually in LOAD, then copied one per cycle to out_data.
// Optional sticky out-of-range write flag enabled by defining STRUCT_COPY_ERR_EN.
module struct_copy_fsm #(
  parameter int               WIDTH      = 32,
  parameter int               FIELDS     = 4,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [((FIELDS > 1) ? $clog2(FIELDS) : 1)-1:0] in_field,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    commit,
  output logic                    in_ready,
  output logic [FIELDS*WIDTH-1:0] out_data,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    err
);

  localparam int FW = (FIELDS > 1) ? $clog2(FIELDS) : 1;
  localparam logic [FW-1:0] LAST = FW'(FIELDS - 1);

  typedef enum logic [7:0] {
    ST_INIT = 8'd0,
    ST_LOAD = 8'd1,
    ST_COPY = 8'd2,
    ST_DONE = 8'd3
  } state_t;

  state_t                        fsm_state_q, fsm_state_d;
  logic [FW-1:0]                 cnt_q, cnt_d;
  logic [FIELDS-1:0][WIDTH-1:0]  staging_q, staging_d;
  logic [FIELDS-1:0][WIDTH-1:0]  out_q, out_d;
  logic                          in_range;

  assign in_range = (32'(in_field) < FIELDS);

  always_comb begin
    fsm_state_d = fsm_state_q;
    cnt_d       = cnt_q;
    staging_d   = staging_q;
    out_d       = out_q;
    case (fsm_state_q)
      ST_INIT: begin
        staging_d   = {FIELDS{INIT_VALUE}};
        cnt_d       = '0;
        fsm_state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // A write in the commit cycle lands before COPY reads staging.
        if (in_valid && in_range) staging_d[in_field] = in_data;
        if (commit) fsm_state_d = ST_COPY;
      end
      ST_COPY: begin
        out_d[cnt_q] = staging_q[cnt_q];
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          fsm_state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: fsm_state_d = ST_LOAD;
      default: fsm_state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_state_q <= ST_INIT;
      cnt_q       <= '0;
      staging_q   <= '0;
      out_q       <= '0;
    end else begin
      fsm_state_q <= fsm_state_d;
      cnt_q       <= cnt_d;
      staging_q   <= staging_d;
      out_q       <= out_d;
    end
  end

  assign in_ready  = (fsm_state_q == ST_LOAD);
  assign out_valid = (fsm_state_q == ST_DONE);
  assign busy      = (fsm_state_q == ST_INIT) || (fsm_state_q == ST_COPY) ||
                     (fsm_state_q == ST_DONE);
  assign out_data  = out_q;

`ifdef STRUCT_COPY_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((fsm_state_q == ST_LOAD) && in_valid && !in_range) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
